// File: rtl/tx_skp_inserter_pkg.sv
// Shared symbol codes, FSM encodings and FIFO entry layout for the TX SKP inserter.
package tx_skp_inserter_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] COM_SYM  = 10'b0011111010;
  localparam logic [SYM_W-1:0] SKP_SYM  = 10'b0011110100;
  localparam logic [SYM_W-1:0] IDLE_SYM = 10'b0000000000;

  typedef enum logic [1:0] {
    ST_BETWEEN = 2'd0,
    ST_PKT     = 2'd1,
    ST_SKP     = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic             pkt_end;
    logic [SYM_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/tx_sym_fifo.sv
// Synchronous symbol FIFO; writes while full are dropped even if a read happens the same cycle.
module tx_sym_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/tx_skp_inserter.sv
// Forwards link-layer symbols to the serializer and inserts a SKP ordered set
// (COM + SKP_LEN x SKP) between packets every SKP_INTERVAL cycles.
module tx_skp_inserter
  import tx_skp_inserter_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             SYMBOL_CLK,
  input  logic             RESET,
  input  logic [SYM_W-1:0] data_in,
  input  logic             iTXVALID,
  input  logic             iPKT_END,
  output logic             TX_READY,
  output logic [SYM_W-1:0] data_out,
  output logic             oTXVALID,
  output logic             SKP_ADDED,
  output logic             SKP_LATE,
  output logic             BUFF_OVERFLOW,
  output logic             TX_UNDERRUN
);

  localparam int CNT_W = $clog2(SKP_INTERVAL);
  localparam int CW    = $clog2(FIFO_DEPTH);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] intv_q, intv_d;
  logic             pending_q, pending_d;
  logic [2:0]       skp_cnt_q, skp_cnt_d;
  logic [SYM_W-1:0] data_out_q, data_d;
  logic             valid_q, valid_d;
  logic             added_q, added_d, late_q, late_d;
  logic             ovf_q, ovf_d, und_q, und_d;
  logic             sched, skp_last, skp_clear;

  logic [CW:0]      fifo_count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [SYM_W:0]   fifo_rdata;
  fifo_entry_t      wr_entry, rd_entry;

  assign TX_READY  = (fifo_count != (CW+1)'(FIFO_DEPTH));
  assign fifo_push = iTXVALID && TX_READY;
  assign wr_entry  = '{pkt_end: iPKT_END, data: data_in};
  assign rd_entry  = fifo_entry_t'(fifo_rdata);

  tx_sym_fifo #(
    .WIDTH (SYM_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (SYMBOL_CLK),
    .rst_i     (RESET),
    .wr_en_i   (fifo_push),
    .wr_data_i (wr_entry),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // A schedule point on the last SKP cycle re-arms pending rather than counting as late.
  assign sched     = (intv_q == CNT_W'(SKP_INTERVAL - 1));
  assign intv_d    = sched ? '0 : intv_q + 1'b1;
  assign skp_last  = (skp_cnt_q == 3'(SKP_LEN - 1));
  assign pending_d = sched | (pending_q & ~skp_clear);
  assign late_d    = sched & pending_q & ~skp_clear;
  assign ovf_d     = iTXVALID & fifo_full;

  always_ff @(posedge SYMBOL_CLK or posedge RESET) begin
    if (RESET) state_q <= ST_BETWEEN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BETWEEN: begin
        if (pending_q)        state_d = ST_SKP;
        else if (!fifo_empty) state_d = rd_entry.pkt_end ? ST_BETWEEN : ST_PKT;
      end
      ST_PKT:  if (!fifo_empty && rd_entry.pkt_end) state_d = ST_BETWEEN;
      ST_SKP:  if (skp_last) state_d = ST_BETWEEN;
      default: state_d = ST_BETWEEN;
    endcase
  end

  always_comb begin
    data_d    = IDLE_SYM;
    valid_d   = 1'b0;
    fifo_pop  = 1'b0;
    skp_clear = 1'b0;
    added_d   = 1'b0;
    und_d     = 1'b0;
    skp_cnt_d = skp_cnt_q;
    case (state_q)
      ST_BETWEEN: begin
        if (pending_q) begin
          data_d    = COM_SYM;
          valid_d   = 1'b1;
          skp_cnt_d = '0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = rd_entry.data;
          valid_d  = 1'b1;
        end
      end
      ST_PKT: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = rd_entry.data;
          valid_d  = 1'b1;
        end else begin
          und_d = 1'b1;
        end
      end
      ST_SKP: begin
        data_d  = SKP_SYM;
        valid_d = 1'b1;
        if (skp_last) begin
          skp_clear = 1'b1;
          added_d   = 1'b1;
        end else begin
          skp_cnt_d = skp_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYMBOL_CLK or posedge RESET) begin
    if (RESET) begin
      intv_q     <= '0;
      pending_q  <= 1'b0;
      skp_cnt_q  <= '0;
      data_out_q <= IDLE_SYM;
      valid_q    <= 1'b0;
      added_q    <= 1'b0;
      late_q     <= 1'b0;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      intv_q     <= intv_d;
      pending_q  <= pending_d;
      skp_cnt_q  <= skp_cnt_d;
      data_out_q <= data_d;
      valid_q    <= valid_d;
      added_q    <= added_d;
      late_q     <= late_d;
      ovf_q      <= ovf_d;
      und_q      <= und_d;
    end
  end

  assign data_out      = data_out_q;
  assign oTXVALID      = valid_q;
  assign SKP_ADDED     = added_q;
  assign SKP_LATE      = late_q;
  assign BUFF_OVERFLOW = ovf_q;
  assign TX_UNDERRUN   = und_q;

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Directed bench for tx_skp_inserter at SKP_INTERVAL=16, SKP_LEN=3.
// Edge 0 is the first rising edge after reset release; "edge k" values are sampled 1 ns after it.
module tb_tx_skp_inserter;

  localparam logic [9:0] COM = 10'b0011111010;
  localparam logic [9:0] SKP = 10'b0011110100;
  localparam logic [9:0] IDL = 10'b0000000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       vld = 1'b0;
  logic       pend = 1'b0;
  logic       tx_ready, o_valid, skp_added, skp_late, ovf, und;
  logic [9:0] dout;

  int tests = 0;
  int fails = 0;

  tx_skp_inserter #(.SKP_INTERVAL(16), .SKP_LEN(3), .FIFO_DEPTH(8)) dut (
    .SYMBOL_CLK    (clk),
    .RESET         (rst),
    .data_in       (din),
    .iTXVALID      (vld),
    .iPKT_END      (pend),
    .TX_READY      (tx_ready),
    .data_out      (dout),
    .oTXVALID      (o_valid),
    .SKP_ADDED     (skp_added),
    .SKP_LATE      (skp_late),
    .BUFF_OVERFLOW (ovf),
    .TX_UNDERRUN   (und)
  );

  always #5 clk = ~clk;

  // flags = {SKP_ADDED, SKP_LATE, BUFF_OVERFLOW, TX_UNDERRUN, TX_READY}
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] d, input logic e);
    vld  = v;
    din  = d;
    pend = e;
  endtask

  task automatic do_reset;
    drive(1'b0, 10'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 10'h155, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({dout, o_valid} !== {IDL, 1'b0}) begin
      fails++;
      $display("FAIL reset_out got d=%h v=%b exp d=%h v=0", dout, o_valid, IDL);
    end
    tests++;
    if ({skp_added, skp_late, ovf, und, tx_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_flags got %b exp 00001", {skp_added, skp_late, ovf, und, tx_ready});
    end
  endtask

  task automatic test_idle_skp;
    logic [9:0] ed;
    logic       ev, ea;
    int         m;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      tick();
      ed = IDL; ev = 1'b0; ea = 1'b0;
      if (k >= 16) begin
        m = (k - 16) % 16;
        if (m == 0) begin ed = COM; ev = 1'b1; end
        else if (m <= 3) begin ed = SKP; ev = 1'b1; ea = (m == 3); end
      end
      tests++;
      if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {ed, ev, ea, 4'b0001}) begin
        fails++;
        $display("FAIL idle_skp k=%0d got d=%h v=%b f=%b exp d=%h v=%b f=%b", k, dout, o_valid,
                 {skp_added, skp_late, ovf, und, tx_ready}, ed, ev, {ea, 4'b0001});
      end
    end
  endtask

  task automatic test_packet;
    logic [9:0] ed;
    logic       ev;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k >= 2 && k <= 6) drive(1'b1, 10'(16'h101 + k - 2), k == 6);
      else                  drive(1'b0, 10'd0, 1'b0);
      tick();
      ed = IDL; ev = 1'b0;
      if (k >= 3 && k <= 7) begin ed = 10'(16'h101 + k - 3); ev = 1'b1; end
      tests++;
      if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {ed, ev, 5'b00001}) begin
        fails++;
        $display("FAIL packet k=%0d got d=%h v=%b und=%b exp d=%h v=%b und=0", k, dout, o_valid, und, ed, ev);
      end
    end
  endtask

  task automatic test_defer;
    logic [9:0] ed;
    logic       ev, ea;
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      if (k >= 5 && k <= 24) drive(1'b1, 10'(16'h200 + k - 5), k == 24);
      else                   drive(1'b0, 10'd0, 1'b0);
      tick();
      ed = IDL; ev = 1'b0; ea = 1'b0;
      if (k >= 6 && k <= 25) begin ed = 10'(16'h200 + k - 6); ev = 1'b1; end
      else if (k == 26) begin ed = COM; ev = 1'b1; end
      else if (k >= 27 && k <= 29) begin ed = SKP; ev = 1'b1; ea = (k == 29); end
      tests++;
      if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {ed, ev, ea, 4'b0001}) begin
        fails++;
        $display("FAIL defer k=%0d got d=%h v=%b add=%b exp d=%h v=%b add=%b", k, dout, o_valid, skp_added, ed, ev, ea);
      end
    end
  endtask

  task automatic test_overflow;
    logic [9:0] ed;
    logic       ev, eo, er;
    do_reset();
    for (int k = 0; k <= 45; k++) begin
      if (k >= 1 && k <= 35) drive(1'b1, 10'(16'h040 + k), 1'b1);
      else                   drive(1'b0, 10'd0, 1'b0);
      tick();
      ed = IDL; ev = 1'b1;
      if (k < 2 || k > 43)          ev = 1'b0;
      else if (k <= 15)             ed = 10'(16'h040 + k - 1);
      else if (k == 16 || k == 32)  ed = COM;
      else if (k <= 19)             ed = SKP;
      else if (k <= 31)             ed = 10'(16'h040 + k - 5);
      else if (k <= 35)             ed = SKP;
      else                          ed = 10'(16'h040 + k - 9);
      eo = (k == 35);
      er = !(k == 34 || k == 35);
      tests++;
      if ({dout, o_valid, skp_late, ovf, und, tx_ready} !== {ed, ev, 1'b0, eo, 1'b0, er}) begin
        fails++;
        $display("FAIL overflow k=%0d got d=%h v=%b ovf=%b rdy=%b exp d=%h v=%b ovf=%b rdy=%b",
                 k, dout, o_valid, ovf, tx_ready, ed, ev, eo, er);
      end
    end
  endtask

  task automatic test_underrun;
    logic [9:0] ed;
    logic       ev, ea, eu;
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      if (k >= 12 && k <= 14)   drive(1'b1, 10'(16'h301 + k - 12), 1'b0);
      else if (k == 18)         drive(1'b1, 10'h304, 1'b0);
      else if (k == 19)         drive(1'b1, 10'h305, 1'b1);
      else                      drive(1'b0, 10'd0, 1'b0);
      tick();
      ed = IDL; ev = 1'b0; ea = 1'b0; eu = 1'b0;
      if (k >= 13 && k <= 15)      begin ed = 10'(16'h301 + k - 13); ev = 1'b1; end
      else if (k >= 16 && k <= 18) eu = 1'b1;
      else if (k == 19)            begin ed = 10'h304; ev = 1'b1; end
      else if (k == 20)            begin ed = 10'h305; ev = 1'b1; end
      else if (k == 21)            begin ed = COM; ev = 1'b1; end
      else if (k >= 22 && k <= 24) begin ed = SKP; ev = 1'b1; ea = (k == 24); end
      tests++;
      if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {ed, ev, ea, 2'b00, eu, 1'b1}) begin
        fails++;
        $display("FAIL underrun k=%0d got d=%h v=%b und=%b exp d=%h v=%b und=%b", k, dout, o_valid, und, ed, ev, eu);
      end
    end
  endtask

  task automatic test_late_reset;
    logic [9:0] ed;
    logic       ev, el;
    do_reset();
    for (int k = 0; k <= 49; k++) begin
      if (k >= 10 && k <= 45)      drive(1'b1, 10'(16'h100 + k - 10), k == 45);
      else if (k == 47 || k == 48) drive(1'b1, 10'h3AA, 1'b1);
      else                         drive(1'b0, 10'd0, 1'b0);
      tick();
      ed = IDL; ev = 1'b0;
      if (k >= 11 && k <= 46)  begin ed = 10'(16'h100 + k - 11); ev = 1'b1; end
      else if (k == 47)        begin ed = COM; ev = 1'b1; end
      else if (k >= 48)        begin ed = SKP; ev = 1'b1; end
      el = (k == 31 || k == 47);
      tests++;
      if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {ed, ev, 1'b0, el, 3'b001}) begin
        fails++;
        $display("FAIL late k=%0d got d=%h v=%b late=%b exp d=%h v=%b late=%b", k, dout, o_valid, skp_late, ed, ev, el);
      end
    end
    drive(1'b0, 10'd0, 1'b0);
    rst = 1'b1;
    #1;
    tests++;
    if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {IDL, 1'b0, 5'b00001}) begin
      fails++;
      $display("FAIL async_reset got d=%h v=%b rdy=%b exp d=%h v=0 rdy=1", dout, o_valid, tx_ready, IDL);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      tests++;
      if ({dout, o_valid, skp_added, skp_late, ovf, und, tx_ready} !== {IDL, 1'b0, 5'b00001}) begin
        fails++;
        $display("FAIL post_reset k=%0d got d=%h v=%b exp d=%h v=0", k, dout, o_valid, IDL);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_skp();
    test_packet();
    test_defer();
    test_overflow();
    test_underrun();
    test_late_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
